// File: rtl/aqed_fifo_monitor_p.sv
// A-QED duplicate-check monitor for FIFO-style memory cores: issues an orig/dup write
// pair, captures both read-side results by sequence number and flags any mismatch.
module aqed_fifo_monitor_p #(
    parameter int DATA_WIDTH   = 16,
    parameter int CNT_WIDTH    = 32,
    parameter int READ_LATENCY = 1,
    parameter int TIMEOUT      = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  exec_dup,
    input  logic                  wen_in,
    input  logic                  ren_in,
    input  logic                  full,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [DATA_WIDTH-1:0] data_out_in,
    input  logic                  valid_out,
    output logic                  issue_orig,
    output logic                  issue_dup,
    output logic                  qed_done,
    output logic                  qed_check,
    output logic                  qed_fail,
    output logic                  qed_timeout
);

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ORIG_SENT,
        WAIT_OUT,
        DONE
    } state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  in_count;
    logic [CNT_WIDTH-1:0]  out_count;
    logic [CNT_WIDTH-1:0]  orig_seq;
    logic [CNT_WIDTH-1:0]  dup_seq;
    logic [DATA_WIDTH-1:0] orig_data;
    logic [DATA_WIDTH-1:0] orig_out;
    logic [DATA_WIDTH-1:0] dup_out;
    logic                  orig_cap;
    logic                  dup_cap;
    logic                  fail_q;
    logic [WAIT_W-1:0]     wait_cnt;

    logic accept_w;
    logic in_sat;
    logic pop;
    logic rd_evt;
    logic consumed;

    function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
        return (v >= WAIT_MAX) ? v : v + WAIT_W'(1);
    endfunction

    // Write side: acceptance, issue decode and pass-through
    assign accept_w   = wen_in & ~full & ~flush & ~reset;
    assign in_sat     = &in_count;
    assign issue_orig = clk_en & (state == IDLE) & exec_dup & accept_w & ~in_sat;
    assign issue_dup  = clk_en & (state == ORIG_SENT) & exec_dup & accept_w & ~in_sat;
    assign data_out   = issue_dup ? orig_data : data_in;

    always_ff @(posedge clk) begin
        if (issue_orig) begin
            orig_data <= data_in;
        end
    end

    // Read side: pop travels READ_LATENCY stages to line up with valid_out
    assign pop = ren_in & ~empty;

    generate
        if (READ_LATENCY == 0) begin : g_rd_comb
            assign rd_evt = pop;
        end else begin : g_rd_pipe
            logic [READ_LATENCY-1:0] rd_vld_p;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_vld_p <= '0;
                end else if (clk_en) begin
                    rd_vld_p <= (rd_vld_p << 1) | READ_LATENCY'(pop);
                end
            end
            assign rd_evt = rd_vld_p[READ_LATENCY-1];
        end
    endgenerate

    assign consumed = rd_evt & valid_out & clk_en;

    // Control, counters and capture registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            in_count    <= '0;
            out_count   <= '0;
            orig_seq    <= '1;
            dup_seq     <= '1;
            orig_out    <= '0;
            dup_out     <= '0;
            orig_cap    <= 1'b0;
            dup_cap     <= 1'b0;
            fail_q      <= 1'b0;
            wait_cnt    <= '0;
            qed_timeout <= 1'b0;
        end else if (clk_en) begin
            if (accept_w) begin
                in_count <= sat_inc_cnt(in_count);
            end

            case (state)
                IDLE: begin
                    if (issue_orig) begin
                        orig_seq <= in_count;
                        state    <= ORIG_SENT;
                    end
                end
                ORIG_SENT: begin
                    if (issue_dup) begin
                        dup_seq <= in_count;
                        state   <= WAIT_OUT;
                    end
                end
                WAIT_OUT: begin
                    if (qed_done) begin
                        state <= DONE;
                    end
                    wait_cnt <= sat_inc_wait(wait_cnt);
                    // Watchdog fires on the edge that brings the count up to TIMEOUT.
                    if ((TIMEOUT > 0) && (sat_inc_wait(wait_cnt) == WAIT_MAX)) begin
                        qed_timeout <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (state != WAIT_OUT) begin
                wait_cnt <= '0;
            end

            if (consumed) begin
                out_count <= sat_inc_cnt(out_count);
                if ((state != IDLE) && !orig_cap && (out_count == orig_seq)) begin
                    orig_out <= data_out_in;
                    orig_cap <= 1'b1;
                end
                if (((state == WAIT_OUT) || (state == DONE)) && !dup_cap && (out_count == dup_seq)) begin
                    dup_out <= data_out_in;
                    dup_cap <= 1'b1;
                end
            end

            if (qed_done && !qed_check) begin
                fail_q <= 1'b1;
            end
        end
    end

    assign qed_done  = orig_cap & dup_cap;
    assign qed_check = (orig_out == dup_out);
    assign qed_fail  = fail_q | (qed_done & ~qed_check);

endmodule

// File: tb/tb_aqed_fifo_monitor_p.sv
// Directed bench for aqed_fifo_monitor_p: four parameterisations share one stimulus
// stream and one FIFO model; each check targets the instance it concerns.
module tb_aqed_fifo_monitor_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, clk_en, flush, exec_dup, wen_in, ren_in, full, empty;
    logic [15:0] data_in;

    // Instance index: 0 = latency 1, 1 = latency 0, 2 = latency 3, 3 = 4-bit counters
    logic [15:0] dout [4];
    logic        iss_o [4];
    logic        iss_d [4];
    logic        done [4];
    logic        chk [4];
    logic        fail [4];
    logic        tmo [4];

    // FIFO model fed by instance 0's write data, with optional fault at index 6
    logic [15:0] mem [32];
    logic [4:0]  wptr, rptr;
    logic        fault;
    logic        pop;
    logic [15:0] rd_data;
    logic        v1, v2, v3;
    logic [15:0] d1, d2, d3;

    assign empty   = (wptr == rptr);
    assign pop     = ren_in & ~empty;
    assign rd_data = (fault && rptr == 5'd6) ? 16'h00A4 : mem[rptr];

    always @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
        end else if (clk_en) begin
            if (wen_in && !full && !flush) begin
                mem[wptr] <= dout[0];
                wptr      <= wptr + 5'd1;
            end
            if (pop) rptr <= rptr + 5'd1;
            v1 <= pop;  d1 <= rd_data;
            v2 <= v1;   d2 <= d1;
            v3 <= v2;   d3 <= d2;
        end
    end

    aqed_fifo_monitor_p #(.DATA_WIDTH(16), .CNT_WIDTH(32), .READ_LATENCY(1), .TIMEOUT(16)) u_l1 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .exec_dup(exec_dup),
        .wen_in(wen_in), .ren_in(ren_in), .full(full), .empty(empty), .data_in(data_in),
        .data_out(dout[0]), .data_out_in(d1), .valid_out(v1), .issue_orig(iss_o[0]),
        .issue_dup(iss_d[0]), .qed_done(done[0]), .qed_check(chk[0]), .qed_fail(fail[0]),
        .qed_timeout(tmo[0]));

    aqed_fifo_monitor_p #(.DATA_WIDTH(16), .CNT_WIDTH(32), .READ_LATENCY(0), .TIMEOUT(16)) u_l0 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .exec_dup(exec_dup),
        .wen_in(wen_in), .ren_in(ren_in), .full(full), .empty(empty), .data_in(data_in),
        .data_out(dout[1]), .data_out_in(rd_data), .valid_out(pop), .issue_orig(iss_o[1]),
        .issue_dup(iss_d[1]), .qed_done(done[1]), .qed_check(chk[1]), .qed_fail(fail[1]),
        .qed_timeout(tmo[1]));

    aqed_fifo_monitor_p #(.DATA_WIDTH(16), .CNT_WIDTH(32), .READ_LATENCY(3), .TIMEOUT(16)) u_l3 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .exec_dup(exec_dup),
        .wen_in(wen_in), .ren_in(ren_in), .full(full), .empty(empty), .data_in(data_in),
        .data_out(dout[2]), .data_out_in(d3), .valid_out(v3), .issue_orig(iss_o[2]),
        .issue_dup(iss_d[2]), .qed_done(done[2]), .qed_check(chk[2]), .qed_fail(fail[2]),
        .qed_timeout(tmo[2]));

    aqed_fifo_monitor_p #(.DATA_WIDTH(16), .CNT_WIDTH(4), .READ_LATENCY(1), .TIMEOUT(16)) u_c4 (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush), .exec_dup(exec_dup),
        .wen_in(wen_in), .ren_in(ren_in), .full(full), .empty(empty), .data_in(data_in),
        .data_out(dout[3]), .data_out_in(d1), .valid_out(v1), .issue_orig(iss_o[3]),
        .issue_dup(iss_d[3]), .qed_done(done[3]), .qed_check(chk[3]), .qed_fail(fail[3]),
        .qed_timeout(tmo[3]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clk_en = 1'b1; flush = 1'b0; exec_dup = 1'b0; wen_in = 1'b0;
        ren_in = 1'b0; full = 1'b0; data_in = 16'h0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Orig 0x00A5 at sequence 3, dup (data_in 0xFFFF) at sequence 6, then seven pops.
    task automatic run_basic(input logic flt);
        fault = flt;
        do_reset();
        wen_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = 16'(16'h0010 + i);
            tick();
        end
        exec_dup = 1'b1; data_in = 16'h00A5;
        #2;
        check("basic issue_orig", 32'(iss_o[0]), 32'd1);
        tick();
        exec_dup = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_in = 16'(16'h0013 + i);
            tick();
        end
        exec_dup = 1'b1; data_in = 16'hFFFF;
        #2;
        check("basic issue_dup", 32'(iss_d[0]), 32'd1);
        check("basic dup data_out", 32'(dout[0]), 32'h00A5);
        check("basic no orig on dup", 32'(iss_o[0]), 32'd0);
        tick();
        wen_in = 1'b0; exec_dup = 1'b0;
        check("basic orig_seq", u_l1.orig_seq, 32'd3);
        check("basic dup_seq", u_l1.dup_seq, 32'd6);
        ren_in = 1'b1;
        repeat (7) tick();
        ren_in = 1'b0;
        check("basic done before 7th read", 32'(done[0]), 32'd0);
        tick();
        check("basic qed_done", 32'(done[0]), 32'd1);
        check("basic qed_check", 32'(chk[0]), flt ? 32'd0 : 32'd1);
        check("basic qed_fail", 32'(fail[0]), flt ? 32'd1 : 32'd0);
    endtask

    initial begin
        fault = 1'b0;
        idle_inputs();
        reset = 1'b1;
        wen_in = 1'b1; exec_dup = 1'b1; data_in = 16'h1234;
        tick();
        #1;
        check("rst issue_orig", 32'(iss_o[0]), 32'd0);
        check("rst issue_dup", 32'(iss_d[0]), 32'd0);
        check("rst qed_done", 32'(done[0]), 32'd0);
        check("rst qed_check", 32'(chk[0]), 32'd1);
        check("rst qed_fail", 32'(fail[0]), 32'd0);
        check("rst qed_timeout", 32'(tmo[0]), 32'd0);
        check("rst data_out", 32'(dout[0]), 32'h1234);
        check("rst in_count", u_l1.in_count, 32'd0);
        check("rst orig_seq", u_l1.orig_seq, 32'hFFFF_FFFF);

        // Matching pair, then the other latencies finish the same stream
        run_basic(1'b0);
        repeat (3) tick();
        check("basic l0 done", 32'(done[1]), 32'd1);
        check("basic l0 check", 32'(chk[1]), 32'd1);
        check("basic l3 done", 32'(done[2]), 32'd1);
        check("basic l3 check", 32'(chk[2]), 32'd1);

        // Corrupted duplicate read-back
        run_basic(1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("fault fail sticky", 32'(fail[0]), 32'd1);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async rst qed_fail", 32'(fail[0]), 32'd0);
        check("async rst qed_check", 32'(chk[0]), 32'd1);
        check("async rst qed_done", 32'(done[0]), 32'd0);
        tick();
        reset = 1'b0;
        fault = 1'b0;

        // Full blocks the orig issue; flush blocks the dup issue
        do_reset();
        wen_in = 1'b1;
        data_in = 16'h0030; tick();
        data_in = 16'h0031; tick();
        full = 1'b1; exec_dup = 1'b1; data_in = 16'h00C3;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("full no issue_orig", 32'(iss_o[0]), 32'd0);
            tick();
        end
        check("full no count", u_l1.in_count, 32'd2);
        full = 1'b0;
        #2;
        check("issue_orig after full", 32'(iss_o[0]), 32'd1);
        tick();
        check("orig_seq after full", u_l1.orig_seq, 32'd2);
        check("in_count after orig", u_l1.in_count, 32'd3);
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("flush no issue_dup", 32'(iss_d[0]), 32'd0);
            tick();
        end
        check("flush no count", u_l1.in_count, 32'd3);
        flush = 1'b0;
        #2;
        check("issue_dup after flush", 32'(iss_d[0]), 32'd1);
        tick();
        check("dup_seq after flush", u_l1.dup_seq, 32'd3);
        wen_in = 1'b0; exec_dup = 1'b0;

        // Watchdog: no pops after the pair
        do_reset();
        wen_in = 1'b1; exec_dup = 1'b1; data_in = 16'h005A;
        tick();
        tick();
        wen_in = 1'b0; exec_dup = 1'b0;
        repeat (15) tick();
        check("timeout not yet", 32'(tmo[0]), 32'd0);
        tick();
        check("timeout at 16", 32'(tmo[0]), 32'd1);
        check("timeout not done", 32'(done[0]), 32'd0);
        #3;
        reset = 1'b1;
        #1;
        check("async rst in WAIT_OUT timeout", 32'(tmo[0]), 32'd0);
        tick();
        reset = 1'b0;

        // Sparse pops with a clock-enable stall; entries 20,21,A5,22,A5,23
        do_reset();
        wen_in = 1'b1;
        data_in = 16'h0020; tick();
        data_in = 16'h0021; tick();
        exec_dup = 1'b1; data_in = 16'h00A5; tick();
        exec_dup = 1'b0; data_in = 16'h0022; tick();
        exec_dup = 1'b1; data_in = 16'hFFFF; tick();
        exec_dup = 1'b0; data_in = 16'h0023; tick();
        wen_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ren_in = (i % 2 == 0);
            tick();
        end
        clk_en = 1'b0; ren_in = 1'b1; wen_in = 1'b1; data_in = 16'h0077;
        repeat (5) tick();
        check("stall in_count", u_l1.in_count, 32'd6);
        check("stall out_count l0", u_l0.out_count, 32'd3);
        check("stall out_count l1", u_l1.out_count, 32'd3);
        check("stall out_count l3", u_l3.out_count, 32'd2);
        clk_en = 1'b1; wen_in = 1'b0;
        for (int i = 6; i < 18; i++) begin
            ren_in = (i % 2 == 0);
            tick();
        end
        ren_in = 1'b0;
        repeat (4) tick();
        check("sparse l0 done", 32'(done[1]), 32'd1);
        check("sparse l0 check", 32'(chk[1]), 32'd1);
        check("sparse l1 done", 32'(done[0]), 32'd1);
        check("sparse l3 done", 32'(done[2]), 32'd1);
        check("sparse l3 check", 32'(chk[2]), 32'd1);
        check("sparse l3 out_count", u_l3.out_count, 32'd6);

        // 4-bit counters: saturation blocks any issue
        do_reset();
        wen_in = 1'b1;
        for (int i = 0; i < 15; i++) begin
            data_in = 16'(16'h0040 + i);
            tick();
        end
        check("c4 in_count sat", 32'(u_c4.in_count), 32'd15);
        exec_dup = 1'b1; data_in = 16'h00A5;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("c4 no issue_orig", 32'(iss_o[3]), 32'd0);
            tick();
        end
        check("c4 in_count held", 32'(u_c4.in_count), 32'd15);
        wen_in = 1'b0; exec_dup = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/aqed_fifo_monitor_p.md
Name: aqed_fifo_monitor_p

Overview:
- Parametrised A-QED duplicate-check monitor for FIFO-style memory-core configurations.
- Sits between the formal harness and the FIFO under test. It passes write data through, and on request it substitutes one "original" write with a later "duplicate" write of the same data.
- It captures both read-side outputs by sequence number and compares them.
- New in this generation: generic data/count widths, configurable read latency, a lock-step state machine, a sticky fail flag, a watchdog timeout and counter saturation.

Parameters:
- DATA_WIDTH, 16, width of write/read data.
- CNT_WIDTH, 32, width of input/output sequence counters.
- READ_LATENCY, 1, cycles from accepted pop (ren_in & ~empty) to data_out_in valid; legal range 0..3.
- TIMEOUT, 1024, max cycles in WAIT_OUT before qed_timeout; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clk_en  in  1  global enable; when low, all state holds.
- flush  in  1  FIFO flush; suppresses issue for that cycle.
- exec_dup  in  1  harness request to issue the orig/dup pair.
- wen_in  in  1  write request toward the FIFO.
- ren_in  in  1  read request toward the FIFO.
- full  in  1  FIFO full.
- empty  in  1  FIFO empty.
- data_in  in  DATA_WIDTH  harness write data.
- data_out  out  DATA_WIDTH  write data driven to the FIFO.
- data_out_in  in  DATA_WIDTH  FIFO read data.
- valid_out  in  1  FIFO read-data valid.
- issue_orig  out  1  this cycle's write is the original (combinational).
- issue_dup  out  1  this cycle's write is the duplicate (combinational).
- qed_done  out  1  both outputs captured.
- qed_check  out  1  captured outputs are equal (meaningful when qed_done=1).
- qed_fail  out  1  sticky: qed_done & mismatch.
- qed_timeout  out  1  sticky watchdog expiry.

Behaviour:

Write acceptance and pass-through:
- accept_w = wen_in & ~full & ~flush & ~reset.
- data_out = orig_data when issue_dup=1; otherwise data_in.

State machine (states IDLE, ORIG_SENT, WAIT_OUT, DONE); all updates require clk_en:
- IDLE: issue_orig = exec_dup & accept_w. On issue_orig, latch orig_data=data_in and orig_seq=in_count, then go to ORIG_SENT.
- ORIG_SENT: issue_dup = exec_dup & accept_w. On issue_dup, latch dup_seq=in_count, then go to WAIT_OUT.
- WAIT_OUT: when both captures are complete, go to DONE. If TIMEOUT>0 and the wait counter reaches TIMEOUT, set qed_timeout; the state stays WAIT_OUT.
- DONE: terminal; exits only on reset.
- Only one issue per cycle. issue_orig and issue_dup are never both 1.

Input counter:
- in_count increments on every accept_w, including orig and dup writes.
- It saturates at all-ones and does not wrap.
- Once saturated, no new orig/dup may issue; the FSM stays in its current state.

Read side:
- pop = ren_in & ~empty.
- A shift pipe of depth READ_LATENCY carries pop. The pipe output is rd_evt; with READ_LATENCY=0, rd_evt = pop.
- A read is consumed when rd_evt & valid_out & clk_en.
- On each consumed read, out_count increments (saturating).
- If out_count==orig_seq and orig is not yet captured, latch orig_out and set orig_cap.
- If out_count==dup_seq and dup is not yet captured, latch dup_out and set dup_cap.
- orig_seq/dup_seq reset to all-ones, so they never match before issue.

Outputs:
- qed_done = orig_cap & dup_cap.
- qed_check = (orig_out == dup_out), full DATA_WIDTH compare.
- qed_fail sets at the first cycle where qed_done & ~qed_check; it is sticky.

Wait counter:
- Counts cycles spent in WAIT_OUT (clk_en only).
- Saturates at TIMEOUT.
- Cleared in every other state.

Boundary conditions:
- flush during ORIG_SENT: no dup issue that cycle; the FSM holds.
- full & wen_in: write not accepted; no count.
- A pop and an issue in the same cycle are independent.
- Reset asserted mid-operation: all state returns to IDLE asynchronously.

Reset values:
- data_out follows data_in.
- issue_orig=0, issue_dup=0, qed_done=0, qed_check=1 (both captures reset to 0), qed_fail=0, qed_timeout=0.
- Counters 0, seqs all-ones, read pipe cleared.

Test Plan:
1. Reset, then 3 plain writes; exec_dup=1 with data_in=0x00A5 (orig_seq=3); 2 writes; dup write with data_in=0xFFFF. Expected: data_out=0x00A5 on the dup write. Pop 7 entries with a FIFO model, READ_LATENCY=1. Expected: qed_done=1 after the 7th consumed read, qed_check=1, qed_fail=0.
2. Same as 1 with a fault-injected FIFO returning 0x00A4 at index 6. Expected: qed_done=1, qed_check=0, qed_fail=1, and qed_fail stays 1 for 10 more cycles.
3. exec_dup with full=1 for 4 cycles, then full=0. Expected: issue_orig only on the first non-full cycle, orig_seq=in_count at that cycle. Repeat with flush=1 during ORIG_SENT. Expected: issue_dup=0 until flush drops.
4. TIMEOUT=16: issue orig+dup, never pop. Expected: qed_timeout=1 exactly 16 cycles after entering WAIT_OUT, qed_done=0.
5. READ_LATENCY=0 and 3 with pop/valid_out toggled every other cycle. Expected: the captured indices still equal orig_seq and dup_seq; clk_en=0 for 5 cycles mid-stream freezes all counters.
6. CNT_WIDTH=4: 15 accepted writes, then exec_dup. Expected: in_count=15 (saturated) and no issue_orig ever. Also assert reset in WAIT_OUT. Expected: outputs at reset values immediately, before the next clk edge.
